// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//   Drives the PLL RST input and qualifies its LOCK output. Each attempt pulses
//   pll_rst for RST_CYCLES cycles. It then waits for lock. Lock must stay high
//   for STABLE_CYCLES consecutive cycles before the downstream domain is released.
//   An attempt that does not reach RUN within LOCK_TIMEOUT cycles is retried.
//   After MAX_RETRY retries the block parks in FAIL with the PLL held in reset.
//   A lock loss while running restarts the PLL and bumps a saturating loss counter.
//   This block runs on the free-running board clock, never on a PLL output.
//
// Ports
//   clk        in   free-running board clock
//   rst_n      in   synchronous reset, active-low
//   pll_lock   in   PLL LOCK, asynchronous to clk
//   restart    in   1-cycle pulse, forces a fresh PLL reset sequence
//   pll_rst    out  PLL RST, active-high (PLL_RST or FAIL)
//   dom_rst_n  out  reset for PLL-clocked logic, active-low (high only in RUN)
//   locked     out  high only in RUN
//   fail       out  high only in FAIL
//   retry_cnt  out  timeouts in the current sequence
//   loss_cnt   out  lock losses seen in RUN, saturating
module pll_lock_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    pll_lock,
  input  logic                                                    restart,
  output logic                                                    pll_rst,
  output logic                                                    dom_rst_n,
  output logic                                                    locked,
  output logic                                                    fail,
  output logic [((MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1)-1:0] retry_cnt,
  output logic [CNT_W-1:0]                                        loss_cnt
);

  localparam int RC_W = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
  localparam int TM_W = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
  localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int RT_W = (MAX_RETRY     > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(LOCK_TIMEOUT - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic            r_lock_p0;
  logic            r_lock_p1;
  state_t          r_state;
  logic [RC_W-1:0] r_rst_cnt;
  logic [TM_W-1:0] r_timer;
  logic [SC_W-1:0] r_stable_cnt;
  logic [RT_W-1:0] r_retry_cnt;
  logic [CNT_W-1:0] r_loss_cnt;
  logic            r_pll_rst;
  logic            r_run;
  logic            r_fail;

  state_t          w_state_nxt;
  logic [RC_W-1:0] w_rst_cnt_nxt;
  logic [TM_W-1:0] w_timer_nxt;
  logic [SC_W-1:0] w_stable_nxt;
  logic [RT_W-1:0] w_retry_nxt;
  logic [CNT_W-1:0] w_loss_nxt;
  logic            w_timeout;
  logic            w_expire;

  // Stage p0/p1: two-flop synchroniser for the asynchronous LOCK input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_p0 <= 1'b0;
      r_lock_p1 <= 1'b0;
    end else begin
      r_lock_p0 <= pll_lock;
      r_lock_p1 <= r_lock_p0;
    end
  end

  // Sequencer: next state and counters, decided from the synchronised lock
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_timer_nxt   = r_timer;
    w_stable_nxt  = r_stable_cnt;
    w_retry_nxt   = r_retry_cnt;
    w_loss_nxt    = r_loss_cnt;
    w_timeout     = (r_timer == TM_LAST);
    w_expire      = 1'b0;

    unique case (r_state)
      S_PLL_RST: begin
        // rst_cnt is only ever non-zero inside this state.
        if (r_rst_cnt == RC_LAST) begin
          w_state_nxt   = S_WAIT_LOCK;
          w_rst_cnt_nxt = '0;
          w_timer_nxt   = '0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RC_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (w_timeout) begin
          w_expire = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TM_W'(1);
          if (r_lock_p1) begin
            w_state_nxt  = S_STABLE;
            w_stable_nxt = '0;
          end
        end
      end
      S_STABLE: begin
        // Finishing qualification on the last allowed cycle still counts as success.
        if (r_lock_p1 && (r_stable_cnt == SC_LAST)) begin
          w_state_nxt = S_RUN;
          w_retry_nxt = '0;
        end else if (w_timeout) begin
          w_expire = 1'b1;
        end else begin
          // The attempt timer keeps running across a lock glitch.
          w_timer_nxt = r_timer + TM_W'(1);
          if (!r_lock_p1) begin
            w_state_nxt = S_WAIT_LOCK;
          end else begin
            w_stable_nxt = r_stable_cnt + SC_W'(1);
          end
        end
      end
      S_RUN: begin
        if (!r_lock_p1) begin
          w_loss_nxt  = sat_inc(r_loss_cnt);
          w_state_nxt = S_PLL_RST;
        end
      end
      S_FAIL: begin
      end
      default: begin
        w_state_nxt = S_PLL_RST;
      end
    endcase

    if (w_expire) begin
      if (r_retry_cnt == RT_MAX) begin
        w_state_nxt = S_FAIL;
      end else begin
        w_retry_nxt = r_retry_cnt + RT_W'(1);
        w_state_nxt = S_PLL_RST;
      end
    end

    // restart overrides everything except the loss count, which records
    // a loss seen in the same cycle and is only cleared by rst_n.
    if (restart) begin
      w_state_nxt   = S_PLL_RST;
      w_rst_cnt_nxt = '0;
      w_timer_nxt   = '0;
      w_stable_nxt  = '0;
      w_retry_nxt   = '0;
    end
  end

  // State register; outputs are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_PLL_RST;
      r_rst_cnt    <= '0;
      r_timer      <= '0;
      r_stable_cnt <= '0;
      r_retry_cnt  <= '0;
      r_loss_cnt   <= '0;
      r_pll_rst    <= 1'b1;
      r_run        <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_timer      <= w_timer_nxt;
      r_stable_cnt <= w_stable_nxt;
      r_retry_cnt  <= w_retry_nxt;
      r_loss_cnt   <= w_loss_nxt;
      r_pll_rst    <= (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAIL);
      r_run        <= (w_state_nxt == S_RUN);
      r_fail       <= (w_state_nxt == S_FAIL);
    end
  end

  assign pll_rst   = r_pll_rst;
  assign dom_rst_n = r_run;
  assign locked    = r_run;
  assign fail      = r_fail;
  assign retry_cnt = r_retry_cnt;
  assign loss_cnt  = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
module tb_pll_lock_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  localparam int CNT_W         = 2;
  localparam int LOSS_MAX      = (1 << CNT_W) - 1;

  localparam int W_PLLRST = 0;
  localparam int W_LOCKED = 1;
  localparam int W_DOM    = 2;
  localparam int W_FAIL   = 3;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             pll_lock = 1'b0;
  logic             restart  = 1'b0;
  logic             pll_rst;
  logic             dom_rst_n;
  logic             locked;
  logic             fail;
  logic [1:0]       retry_cnt;
  logic [CNT_W-1:0] loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .restart  (restart),
    .pll_rst  (pll_rst),
    .dom_rst_n(dom_rst_n),
    .locked   (locked),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phases, a reset countdown, elapsed attempt time, and the
  // length of the current run of synchronised-lock-high cycles.
  localparam int P_RST  = 0;
  localparam int P_ACQ  = 1;
  localparam int P_RUN  = 2;
  localparam int P_FAIL = 3;

  int m_ph      = P_RST;
  int m_left    = RST_CYCLES;
  int m_elapsed = 0;
  int m_streak  = 0;
  int m_retries = 0;
  int m_losses  = 0;
  bit m_h0      = 1'b0;
  bit m_h1      = 1'b0;

  task automatic model_step();
    bit ls;
    ls = m_h1;
    if (!rst_n) begin
      m_ph = P_RST; m_left = RST_CYCLES; m_retries = 0; m_losses = 0;
      m_h0 = 1'b0; m_h1 = 1'b0;
    end else begin
      m_h1 = m_h0;
      m_h0 = pll_lock;
      case (m_ph)
        P_RST: begin
          m_left--;
          if (m_left == 0) begin m_ph = P_ACQ; m_elapsed = 0; m_streak = 0; end
        end
        P_ACQ: begin
          m_elapsed++;
          m_streak = ls ? m_streak + 1 : 0;
          // first lock_s-high cycle moves to qualification, then STABLE_CYCLES more
          if (m_streak == STABLE_CYCLES + 1) begin
            m_ph = P_RUN; m_retries = 0;
          end else if (m_elapsed == LOCK_TIMEOUT) begin
            if (m_retries == MAX_RETRY) m_ph = P_FAIL;
            else begin m_retries++; m_ph = P_RST; m_left = RST_CYCLES; end
          end
        end
        P_RUN: begin
          if (!ls) begin
            if (m_losses < LOSS_MAX) m_losses++;
            m_ph = P_RST; m_left = RST_CYCLES;
          end
        end
        default: begin end
      endcase
      if (restart) begin m_ph = P_RST; m_left = RST_CYCLES; m_retries = 0; end
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic a, r, f;
    a = (m_ph == P_RST) || (m_ph == P_FAIL);
    r = (m_ph == P_RUN);
    f = (m_ph == P_FAIL);
    return {24'd0, a, r, r, f, 2'(m_retries), 2'(m_losses)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("outs", {24'd0, pll_rst, dom_rst_n, locked, fail, retry_cnt, loss_cnt}, model_vec());
  endtask

  function automatic logic obs(input int w);
    case (w)
      W_PLLRST: obs = pll_rst;
      W_LOCKED: obs = locked;
      W_DOM:    obs = dom_rst_n;
      default:  obs = fail;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, input logic v, input int bound,
                          output int n);
    n = 0;
    while (obs(w) !== v && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(obs(w)), 32'(v));
  endtask

  initial begin
    int n;
    int seg;

    // Reset values, first pulse, first lock
    rst_n = 1'b0; pll_lock = 1'b0; restart = 1'b0;
    step(); step();
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_dom", 32'(dom_rst_n), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_cnts", {28'd0, retry_cnt, loss_cnt}, 0);
    rst_n = 1'b1;
    wait_for("s1_fall", W_PLLRST, 1'b0, 20, n);
    chk("s1_pulse_len", n, RST_CYCLES);
    repeat (9) step();
    pll_lock = 1'b1;
    wait_for("s1_lock", W_LOCKED, 1'b1, 40, n);
    chk("s1_lock_lat", n, 2 + STABLE_CYCLES + 1);
    chk("s1_dom", 32'(dom_rst_n), 1);
    chk("s1_retry", 32'(retry_cnt), 0);

    // One-cycle glitch during qualification: re-qualify from scratch
    pll_lock = 1'b0; restart = 1'b1; step(); restart = 1'b0;
    chk("s2_restart_no_loss", 32'(loss_cnt), 0);
    wait_for("s2_fall", W_PLLRST, 1'b0, 20, n);
    pll_lock = 1'b1; repeat (6) step();
    pll_lock = 1'b0; step();
    pll_lock = 1'b1;
    wait_for("s2_relock", W_LOCKED, 1'b1, 60, n);
    // release seen two edges later, then one cycle to re-enter, then STABLE_CYCLES
    chk("s2_relock_lat", n, STABLE_CYCLES + 3);

    // Glitch late in the attempt: the timer must keep running and time out
    pll_lock = 1'b0; restart = 1'b1; step(); restart = 1'b0;
    wait_for("s2b_fall", W_PLLRST, 1'b0, 20, n);
    repeat (85) step();
    pll_lock = 1'b1; repeat (6) step();
    pll_lock = 1'b0; step();
    pll_lock = 1'b1;
    repeat (19) step();
    chk("s2b_locked", 32'(locked), 0);
    chk("s2b_retry", 32'(retry_cnt), 1);

    // Lock never asserts: retries, then FAIL, then restart
    pll_lock = 1'b0; restart = 1'b1; step(); restart = 1'b0;
    for (int p = 0; p <= MAX_RETRY; p++) begin
      chk($sformatf("s3_retry%0d", p), 32'(retry_cnt), p);
      wait_for("s3_fall", W_PLLRST, 1'b0, 20, n);
      chk("s3_pulse_len", n, RST_CYCLES);
      wait_for("s3_rise", W_PLLRST, 1'b1, 150, n);
      chk("s3_wait_len", n, LOCK_TIMEOUT);
    end
    chk("s3_fail", 32'(fail), 1);
    chk("s3_dom", 32'(dom_rst_n), 0);
    repeat (30) step();
    chk("s3_fail_hold", 32'(fail), 1);
    chk("s3_pll_rst_hold", 32'(pll_rst), 1);
    restart = 1'b1; step(); restart = 1'b0;
    chk("s3_fail_clr", 32'(fail), 0);
    chk("s3_retry_clr", 32'(retry_cnt), 0);
    wait_for("s3_new_fall", W_PLLRST, 1'b0, 20, n);
    chk("s3_new_pulse", n, RST_CYCLES);

    // Four lock losses in RUN: loss_cnt saturates
    rst_n = 1'b0; step(); rst_n = 1'b1; pll_lock = 1'b1;
    wait_for("s4_lock", W_LOCKED, 1'b1, 60, n);
    for (int k = 1; k <= 4; k++) begin
      pll_lock = 1'b0;
      wait_for("s4_drop", W_DOM, 1'b0, 10, n);
      chk("s4_drop_lat", n, 3);
      chk($sformatf("s4_loss%0d", k), 32'(loss_cnt), (k < LOSS_MAX) ? k : LOSS_MAX);
      pll_lock = 1'b1;
      wait_for("s4_relock", W_LOCKED, 1'b1, 60, n);
    end

    // restart in the same cycle the FSM sees the lock loss
    rst_n = 1'b0; step(); rst_n = 1'b1; pll_lock = 1'b1;
    wait_for("s5_lock", W_LOCKED, 1'b1, 60, n);
    pll_lock = 1'b0; step(); step();
    restart = 1'b1; step(); restart = 1'b0;
    chk("s5_loss", 32'(loss_cnt), 1);
    chk("s5_locked", 32'(locked), 0);
    chk("s5_pll_rst", 32'(pll_rst), 1);
    chk("s5_retry", 32'(retry_cnt), 0);
    pll_lock = 1'b1;
    wait_for("s5_fall", W_PLLRST, 1'b0, 20, n);
    chk("s5_pulse_len", n, RST_CYCLES);

    // rst_n in the middle of qualification
    repeat (5) step();
    rst_n = 1'b0; step();
    chk("s6_outs", {24'd0, pll_rst, dom_rst_n, locked, fail, retry_cnt, loss_cnt},
        {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
    rst_n = 1'b1;

    // Randomised lock behaviour with occasional restarts and resets
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        pll_lock = ~pll_lock;
        if (pll_lock) seg = int'($urandom_range(1, 150));
        else if ($urandom_range(0, 7) == 0) seg = int'($urandom_range(100, 400));
        else seg = int'($urandom_range(1, 30));
      end
      seg--;
      restart = ($urandom_range(0, 249) == 0);
      rst_n   = ($urandom_range(0, 999) != 0);
      step();
    end
    restart = 1'b0; rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
